uart_frame_tx: RTL and testbench
================================

Name: uart_frame_tx

Overview:
Buffered, parametrised successor to the single-byte UART send FSM in the top level. It accepts bytes into an internal FIFO, then on a start request drives the existing uart_transmit block byte by byte using its send/ready handshake. Two modes:
- raw: payload only.
- framed: header byte, length byte, payload, XOR checksum.

It sits between the configuration/status logic and uart_transmit, replacing the button-driven IDLE/START_SEND/SENDING loop.

Parameters:
DATA_W, 8, width of a UART byte and of every FIFO entry.
ADDR_W, 4, FIFO address width; depth = 2**ADDR_W (must satisfy depth <= 2**DATA_W - 1).
HEADER, 8'hA5, first byte of a framed transfer (DATA_W wide).

Ports:
clk  in  1  system clock; all logic on posedge.
rst  in  1  synchronous, active-high reset.
wr_en  in  1  push wr_data into the FIFO this cycle.
wr_data  in  DATA_W  byte to push.
start  in  1  request transmission of the current FIFO contents.
framed  in  1  mode for the request, sampled with start (1 = framed, 0 = raw).
tx_ready  in  1  ready from uart_transmit (high = idle).
tx_send  out  1  one-cycle send pulse to uart_transmit.
tx_data  out  DATA_W  byte presented to uart_transmit.
full  out  1  FIFO holds 2**ADDR_W entries.
count  out  ADDR_W+1  current FIFO occupancy.
busy  out  1  a frame is in progress.
done  out  1  one-cycle pulse after the last byte of a frame completes.
overflow  out  1  sticky: a write was attempted while full.

Behaviour:
- Reset (rst=1 at a posedge): FIFO emptied, count=0, full=0, tx_send=0, tx_data=0, busy=0, done=0, overflow=0, state=IDLE. Reset mid-frame aborts immediately; no further tx_send; remaining bytes discarded.
- FIFO writes:
  - wr_en && !full: write accepted in any state, including while busy.
  - wr_en && full: write dropped, overflow<=1 until rst.
  - Same-cycle write and pop: count unchanged. Pointers wrap modulo 2**ADDR_W.
- Start acceptance:
  - Accepted only in IDLE. start while busy is ignored, not queued.
  - On acceptance, the mode and frame length N = count are latched. Bytes written later belong to the next frame.
  - Raw mode with N=0: start ignored; busy stays 0; no done.
  - Framed mode with N=0 is legal and sends HEADER, 0x00, 0x00.
- Byte sequence:
  - raw: N payload bytes.
  - framed: HEADER, N (zero-extended to DATA_W), N payload bytes, checksum.
  - checksum = XOR of the length byte and all payload bytes.
  - Payload bytes are popped from the FIFO as each one is loaded into tx_data.
- States:
  - IDLE: busy=0. On an accepted start -> LOAD.
  - LOAD: tx_data <= next byte; busy=1 from this cycle -> PULSE.
  - PULSE: tx_send=1 for exactly one cycle -> WAIT_LO.
  - WAIT_LO: hold until tx_ready==0 -> WAIT_HI.
  - WAIT_HI: hold until tx_ready==1. More bytes remain -> LOAD; last byte -> DONE.
  - DONE: done=1 for one cycle, busy=0 -> IDLE.
- Timing:
  - tx_data is stable from LOAD until WAIT_HI exits.
  - Latency: start sampled at edge t gives tx_send high during the cycle after edge t+2.
  - Per-byte overhead is 3 clk beyond the uart_transmit busy time.
- tx_ready is assumed to fall within a bounded number of cycles after tx_send. No timeout is implemented; this block is not responsible for a stuck tx_ready.
- Registered outputs only; no combinational path from inputs to outputs.

Test Plan:
- Raw 3-byte frame: write 11,22,33; start, framed=0; stub uart_transmit drops ready 1 clk after send and holds it low 20 clk.
  -> tx_data sequence 11,22,33; exactly 3 tx_send pulses; one done pulse; count=0 at end.
- Framed 2-byte frame: write 0x0F,0xF0; start, framed=1.
  -> bytes A5,02,0F,F0,FD (checksum 02^0F^F0); busy high throughout, then one done.
- Zero-length: start, framed=0 with empty FIFO -> busy stays 0, no tx_send, no done.
  Then start, framed=1 -> A5,00,00 sent, then done.
- Overflow and concurrency: write 17 bytes to a 16-deep FIFO -> full=1, count=16, overflow=1.
  Start raw, then write 0x77 during the frame -> 16 bytes sent in order; count=1 after done; overflow stays 1.
- Start while busy: assert start again mid-frame -> ignored; byte count of the frame and done count unchanged.
- Reset mid-frame: assert rst during WAIT_LO of byte 2 -> next cycle all outputs at reset values; no further tx_send; count=0.
  A new frame after reset transmits correctly.

Source files
------------

// File: rtl/uart_frame_tx.sv
// Buffered UART frame sender: queues bytes in a FIFO and feeds them to uart_transmit
// through its send/ready handshake, optionally wrapped as header/length/payload/checksum.
module uart_frame_tx #(
    parameter int                DATA_W = 8,
    parameter int                ADDR_W = 4,
    parameter logic [DATA_W-1:0] HEADER = 8'hA5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              start,
    input  logic              framed,
    input  logic              tx_ready,
    output logic              tx_send,
    output logic [DATA_W-1:0] tx_data,
    output logic              full,
    output logic [ADDR_W:0]   count,
    output logic              busy,
    output logic              done,
    output logic              overflow
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W:0] CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_PULSE, S_WAIT_LO, S_WAIT_HI, S_DONE
    } state_t;

    typedef enum logic [1:0] {
        B_HDR, B_LEN, B_PAY, B_CSUM
    } seq_t;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    state_t            state;
    seq_t              seq;
    logic              framed_q;
    logic              last_q;
    logic [ADDR_W:0]   frame_len;
    logic [ADDR_W:0]   rem;
    logic [DATA_W-1:0] csum;
    logic              push;
    logic              pop;

    // full derives from the count register, so it is still a registered output
    assign full = count[ADDR_W];
    assign push = wr_en && !full;
    assign pop  = (state == S_LOAD) && (seq == B_PAY);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            state     <= S_IDLE;
            seq       <= B_HDR;
            framed_q  <= 1'b0;
            last_q    <= 1'b0;
            frame_len <= '0;
            rem       <= '0;
            tx_send   <= 1'b0;
            tx_data   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (wr_en && full) begin
                overflow <= 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase

            tx_send <= 1'b0;
            done    <= 1'b0;

            case (state)
                S_IDLE: begin
                    // Raw with nothing queued has nothing to send; framed still sends an empty frame
                    if (start && (framed || count != '0)) begin
                        framed_q  <= framed;
                        frame_len <= count;
                        rem       <= count;
                        seq       <= framed ? B_HDR : B_PAY;
                        busy      <= 1'b1;
                        state     <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    state <= S_PULSE;
                    case (seq)
                        B_HDR: begin
                            tx_data <= HEADER;
                            seq     <= B_LEN;
                            last_q  <= 1'b0;
                        end
                        B_LEN: begin
                            tx_data <= DATA_W'(frame_len);
                            csum    <= DATA_W'(frame_len);
                            seq     <= (rem == '0) ? B_CSUM : B_PAY;
                            last_q  <= 1'b0;
                        end
                        B_PAY: begin
                            tx_data <= mem[rd_ptr];
                            csum    <= csum ^ mem[rd_ptr];
                            rem     <= rem - 1'b1;
                            if (rem == CNT_ONE && framed_q) begin
                                seq    <= B_CSUM;
                                last_q <= 1'b0;
                            end else begin
                                last_q <= (rem == CNT_ONE);
                            end
                        end
                        default: begin
                            tx_data <= csum;
                            last_q  <= 1'b1;
                        end
                    endcase
                end
                S_PULSE: begin
                    tx_send <= 1'b1;
                    state   <= S_WAIT_LO;
                end
                S_WAIT_LO: begin
                    if (!tx_ready) begin
                        state <= S_WAIT_HI;
                    end
                end
                S_WAIT_HI: begin
                    if (tx_ready) begin
                        if (last_q) begin
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            state <= S_DONE;
                        end else begin
                            state <= S_LOAD;
                        end
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_frame_tx.sv
// Directed bench for uart_frame_tx with a uart_transmit stub that drops ready
// one clock after each send and holds it low for 20 clocks.
module tb_uart_frame_tx;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_en = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       start = 1'b0;
    logic       framed = 1'b0;
    logic       tx_ready;
    logic       tx_send;
    logic [7:0] tx_data;
    logic       full;
    logic [4:0] count;
    logic       busy;
    logic       done;
    logic       overflow;

    always #5 clk = ~clk;

    uart_frame_tx #(.DATA_W(8), .ADDR_W(4), .HEADER(8'hA5)) dut (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .start    (start),
        .framed   (framed),
        .tx_ready (tx_ready),
        .tx_send  (tx_send),
        .tx_data  (tx_data),
        .full     (full),
        .count    (count),
        .busy     (busy),
        .done     (done),
        .overflow (overflow)
    );

    // uart_transmit stand-in
    int lo_cnt = 0;
    always @(posedge clk) begin
        if (rst) lo_cnt <= 0;
        else if (tx_send) lo_cnt <= 20;
        else if (lo_cnt != 0) lo_cnt <= lo_cnt - 1;
    end
    assign tx_ready = (lo_cnt == 0);

    int         sends = 0;
    int         dones = 0;
    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];

    always @(negedge clk) begin
        if (tx_send) begin
            sends <= sends + 1;
            got_q.push_back(tx_data);
        end
        if (done) dones <= dones + 1;
    end

    int n_checks = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [7:0] b);
        wr_en   = 1'b1;
        wr_data = b;
        @(negedge clk);
        wr_en   = 1'b0;
    endtask

    task automatic begin_frame(input logic f);
        start  = 1'b1;
        framed = f;
        @(negedge clk);
        start  = 1'b0;
        framed = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int max, output int busy_low);
        int  k;
        bit  seen;
        k        = 0;
        seen     = 1'b0;
        busy_low = 0;
        while (k < max && !seen) begin
            @(negedge clk);
            k++;
            if (done) seen = 1'b1;
            else if (!busy) busy_low++;
        end
        check(tag, 32'(seen), 32'd1);
        repeat (2) @(negedge clk);
    endtask

    task automatic compare_seq(input string tag);
        check($sformatf("%s_len", tag), 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < got_q.size())
                check($sformatf("%s[%0d]", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
        end
    endtask

    initial begin
        int s0;
        int d0;
        int bl;
        int k;
        int n;

        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_count", 32'(count), 0);
        check("rst_full", 32'(full), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_overflow", 32'(overflow), 0);
        check("rst_tx_send", 32'(tx_send), 0);
        check("rst_tx_data", 32'(tx_data), 0);

        // raw three-byte frame
        got_q.delete();
        s0 = sends; d0 = dones;
        push(8'h11); push(8'h22); push(8'h33);
        check("raw_count_loaded", 32'(count), 3);
        begin_frame(1'b0);
        k = 0;
        while (!tx_send && k < 10) begin
            @(negedge clk);
            k++;
        end
        check("raw_latency", 32'(k), 2);
        wait_done("raw_done", 500, bl);
        exp_q = '{8'h11, 8'h22, 8'h33};
        compare_seq("raw_bytes");
        check("raw_sends", 32'(sends - s0), 3);
        check("raw_dones", 32'(dones - d0), 1);
        check("raw_count_end", 32'(count), 0);

        // framed two-byte frame
        got_q.delete();
        s0 = sends; d0 = dones;
        push(8'h0F); push(8'hF0);
        begin_frame(1'b1);
        wait_done("frm_done", 500, bl);
        check("frm_busy_gap", 32'(bl), 0);
        exp_q = '{8'hA5, 8'h02, 8'h0F, 8'hF0, 8'hFD};
        compare_seq("frm_bytes");
        check("frm_dones", 32'(dones - d0), 1);

        // zero length: raw ignored, framed sends an empty frame
        got_q.delete();
        s0 = sends; d0 = dones;
        begin_frame(1'b0);
        n = 0;
        repeat (10) begin
            @(negedge clk);
            if (busy) n++;
        end
        check("zero_raw_busy", 32'(n), 0);
        check("zero_raw_sends", 32'(sends - s0), 0);
        check("zero_raw_dones", 32'(dones - d0), 0);
        begin_frame(1'b1);
        wait_done("zero_frm_done", 300, bl);
        exp_q = '{8'hA5, 8'h00, 8'h00};
        compare_seq("zero_frm_bytes");
        check("zero_frm_dones", 32'(dones - d0), 1);

        // overflow, write during frame, start while busy
        got_q.delete();
        exp_q.delete();
        for (int i = 1; i <= 16; i++) begin
            push(8'(i));
            exp_q.push_back(8'(i));
        end
        check("ovf_before", 32'(overflow), 0);
        push(8'hEE);
        check("ovf_full", 32'(full), 1);
        check("ovf_count", 32'(count), 16);
        check("ovf_flag", 32'(overflow), 1);
        s0 = sends; d0 = dones;
        begin_frame(1'b0);
        repeat (5) @(negedge clk);
        push(8'h77);
        repeat (30) @(negedge clk);
        check("busy_mid_frame", 32'(busy), 1);
        begin_frame(1'b1);
        wait_done("ovf_done", 2000, bl);
        compare_seq("ovf_bytes");
        check("ovf_sends", 32'(sends - s0), 16);
        check("ovf_count_end", 32'(count), 1);
        check("ovf_sticky", 32'(overflow), 1);
        check("ovf_dones", 32'(dones - d0), 1);
        repeat (60) @(negedge clk);
        check("busy_start_not_queued", 32'(sends - s0), 16);
        check("busy_idle_after", 32'(busy), 0);

        // reset mid-frame while waiting on byte 2
        got_q.delete();
        push(8'hAA); push(8'hBB);
        s0 = sends;
        begin_frame(1'b0);
        n = 0; k = 0;
        while (n < 2 && k < 200) begin
            @(negedge clk);
            k++;
            if (tx_send) n++;
        end
        check("mid_second_send", 32'(n), 2);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_tx_send", 32'(tx_send), 0);
        check("mid_rst_tx_data", 32'(tx_data), 0);
        check("mid_rst_busy", 32'(busy), 0);
        check("mid_rst_done", 32'(done), 0);
        check("mid_rst_count", 32'(count), 0);
        check("mid_rst_full", 32'(full), 0);
        check("mid_rst_overflow", 32'(overflow), 0);
        repeat (60) @(negedge clk);
        check("mid_no_more_sends", 32'(sends - s0), 2);
        exp_q = '{8'h77, 8'hAA};
        compare_seq("mid_bytes");

        got_q.delete();
        d0 = dones;
        push(8'h5A);
        begin_frame(1'b1);
        wait_done("post_rst_done", 500, bl);
        exp_q = '{8'hA5, 8'h01, 8'h5A, 8'h5B};
        compare_seq("post_rst_bytes");
        check("post_rst_dones", 32'(dones - d0), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
